// File: rtl/crane_pkg.sv
// crane_pkg: shared action codes and controller state encoding for the crane controller.
// Contents: ACT_* action codes driven on the action output, state_e FSM states.
// FAULT is present only when CRANE_HOOK_TIMEOUT_EN is defined; its action code is ACT_NOP.
package crane_pkg;
   localparam logic [2:0] ACT_DN  = 3'd0;
   localparam logic [2:0] ACT_A1  = 3'd1;
   localparam logic [2:0] ACT_UP  = 3'd2;
   localparam logic [2:0] ACT_A2  = 3'd3;
   localparam logic [2:0] ACT_R1  = 3'd4;
   localparam logic [2:0] ACT_R2  = 3'd5;
   localparam logic [2:0] ACT_NOP = 3'd6;
   localparam logic [2:0] ACT_ROT = 3'd7;
   typedef enum logic [3:0] {
      S_IDLE, S_ROT_PICK, S_LOWER_PICK, S_HOOK, S_RAISE,
      S_ROT_DROP, S_LOWER_DROP, S_UNHOOK, S_RAISE_HOME, S_ROT_HOME
`ifdef CRANE_HOOK_TIMEOUT_EN
      , S_FAULT
`endif
   } state_e;
endpackage

// File: rtl/crane_ctrl_gen2_if.sv
// crane_ctrl_gen2_if: operator command channel of the crane controller.
// Signals: cmd_valid/cmd_ready handshake, pick_angle/drop_angle targets, abort request.
// master = operator side, slave = controller side.
interface crane_ctrl_gen2_if #(parameter int ANG_W = 2);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [ANG_W-1:0] pick_angle;
   logic [ANG_W-1:0] drop_angle;
   logic             abort;
   modport master (output cmd_valid, pick_angle, drop_angle, abort, input cmd_ready);
   modport slave  (input cmd_valid, pick_angle, drop_angle, abort, output cmd_ready);
endinterface

// File: rtl/crane_rotator.sv
// crane_rotator: shortest-path one-position-per-TURN_TIME rotation toward a target angle.
// Ports: clk, reset (async active-low), en (a rotate state is active), clr (drop progress),
//        target, angle (current), angle_nxt (angle after this cycle), arrive (angle == target).
module crane_rotator #(
   parameter int ANG_W     = 2,
   parameter int TURN_TIME = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [ANG_W-1:0] target,
   input  logic [ANG_W-1:0] angle,
   output logic [ANG_W-1:0] angle_nxt,
   output logic             arrive
);
   localparam int CW = TURN_TIME > 1 ? $clog2(TURN_TIME) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TURN_TIME - 1);
   localparam logic [ANG_W-1:0] HALF = ANG_W'(1) << (ANG_W - 1);
   logic [CW-1:0]    cnt;
   logic [ANG_W-1:0] diff;
   logic             step;
   assign diff      = target - angle;
   assign arrive    = en && diff == '0;
   assign step      = en && !clr && diff != '0 && cnt == CMAX;
   // diff == HALF is a tie between directions and resolves to +1
   assign angle_nxt = !step ? angle : diff <= HALF ? angle + ANG_W'(1) : angle - ANG_W'(1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else cnt <= (!en || clr || diff == '0 || cnt == CMAX) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/crane_ctrl_gen2.sv
// crane_ctrl_gen2: crane pick/drop sequencer with shortest-path rotation and abort.
// Ports: clk, reset (async active-low), cmd (crane_ctrl_gen2_if.slave: valid/ready, angles, abort),
//        hooked/unhooked sensors, angle/height position, action code, busy, done pulse,
//        sticky aborted, fault (only with CRANE_HOOK_TIMEOUT_EN: HOOK/UNHOOK timeout -> FAULT).
module crane_ctrl_gen2
   import crane_pkg::*;
#(
   parameter int ANG_W        = 2,
   parameter int H_W          = 3,
   parameter int DOWN_TO      = 0,
   parameter int UP_TO        = 4,
   parameter int START_HEIGHT = 6,
   parameter int TURN_TIME    = 3,
   parameter int HOOK_TMO     = 8
) (
   input  logic             clk,
   input  logic             reset,
   crane_ctrl_gen2_if.slave cmd,
   input  logic             hooked,
   input  logic             unhooked,
   output logic [ANG_W-1:0] angle,
   output logic [H_W-1:0]   height,
   output logic [2:0]       action,
   output logic             busy,
   output logic             done,
   output logic             aborted
`ifdef CRANE_HOOK_TIMEOUT_EN
   ,
   output logic             fault
`endif
);
   localparam logic [H_W-1:0] HD = H_W'(DOWN_TO);
   localparam logic [H_W-1:0] HU = H_W'(UP_TO);
   localparam logic [H_W-1:0] HS = H_W'(START_HEIGHT);
   if (TURN_TIME < 1 || HOOK_TMO < 1 || DOWN_TO >= UP_TO || DOWN_TO >= START_HEIGHT) begin : g_param_chk
      $error("crane_ctrl_gen2: invalid parameters");
   end
   state_e           state, nxt;
   logic [ANG_W-1:0] pick, drop, rot_tgt, ang_nxt;
   logic [H_W-1:0]   v_tgt, h_mv;
   logic             acc, rot_en, arrive, reached, v_en, ab_hit, homed;
   assign acc           = cmd.cmd_valid && cmd.cmd_ready;
   assign cmd.cmd_ready = state == S_IDLE;
   assign busy          = state != S_IDLE;
   assign rot_en        = state inside {S_ROT_PICK, S_ROT_DROP, S_ROT_HOME};
   assign rot_tgt       = state == S_ROT_PICK ? pick : state == S_ROT_DROP ? drop : '0;
   assign v_tgt         = state == S_RAISE ? HU : state == S_RAISE_HOME ? HS : HD;
   assign h_mv          = height < v_tgt ? height + H_W'(1) : height > v_tgt ? height - H_W'(1) : height;
   assign reached       = h_mv == v_tgt;
   crane_rotator #(.ANG_W(ANG_W), .TURN_TIME(TURN_TIME)) u_rot (
      .clk(clk), .reset(reset), .en(rot_en), .clr(ab_hit),
      .target(rot_tgt), .angle(angle), .angle_nxt(ang_nxt), .arrive(arrive)
   );
`ifdef CRANE_HOOK_TIMEOUT_EN
   localparam int TW = $clog2(HOOK_TMO + 1);
   logic [TW-1:0] tmo;
   logic          tmo_hit;
   assign tmo_hit = tmo == TW'(HOOK_TMO - 1);
   assign fault   = state == S_FAULT;
   always_ff @(posedge clk or negedge reset)
      if (!reset) tmo <= '0;
      else tmo <= (state == S_HOOK || state == S_UNHOOK) ? tmo + TW'(1) : '0;
`endif
   always_comb begin
      nxt    = state;
      action = ACT_NOP;
      v_en   = 1'b0;
      ab_hit = 1'b0;
      case (state)
         S_IDLE: begin
            action = homed ? ACT_R2 : ACT_NOP;
            nxt    = acc ? S_ROT_PICK : S_IDLE;
         end
         S_ROT_PICK: begin
            action = ACT_ROT;
            ab_hit = cmd.abort;
            nxt    = cmd.abort ? S_RAISE_HOME : arrive ? S_LOWER_PICK : state;
         end
         S_LOWER_PICK: begin
            action = ACT_DN;
            ab_hit = cmd.abort;
            v_en   = !cmd.abort;
            nxt    = cmd.abort ? S_RAISE_HOME : reached ? S_HOOK : state;
         end
         S_HOOK: begin
            action = ACT_A1;
            ab_hit = cmd.abort && !hooked;
            nxt    = hooked ? S_RAISE : cmd.abort ? S_RAISE_HOME : state;
`ifdef CRANE_HOOK_TIMEOUT_EN
            if (!hooked && !cmd.abort && tmo_hit) nxt = S_FAULT;
`endif
         end
         S_RAISE: begin
            action = ACT_UP;
            v_en   = 1'b1;
            nxt    = reached ? S_ROT_DROP : state;
         end
         S_ROT_DROP: begin
            action = ACT_ROT;
            nxt    = arrive ? S_LOWER_DROP : state;
         end
         S_LOWER_DROP: begin
            action = ACT_DN;
            v_en   = 1'b1;
            nxt    = reached ? S_UNHOOK : state;
         end
         S_UNHOOK: begin
            action = ACT_A2;
            nxt    = unhooked ? S_RAISE_HOME : state;
`ifdef CRANE_HOOK_TIMEOUT_EN
            if (!unhooked && tmo_hit) nxt = S_FAULT;
`endif
         end
         S_RAISE_HOME: begin
            action = ACT_R1;
            v_en   = 1'b1;
            nxt    = reached ? S_ROT_HOME : state;
         end
         S_ROT_HOME: begin
            action = ACT_ROT;
            nxt    = arrive ? S_IDLE : state;
         end
`ifdef CRANE_HOOK_TIMEOUT_EN
         S_FAULT: nxt = S_FAULT;
`endif
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= S_IDLE;
         angle   <= '0;
         height  <= HS;
         pick    <= '0;
         drop    <= '0;
         homed   <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         state   <= nxt;
         angle   <= ang_nxt;
         if (v_en) height <= h_mv;
         done    <= state == S_ROT_HOME && arrive;
         homed   <= acc ? 1'b0 : (state == S_ROT_HOME && arrive) ? 1'b1 : homed;
         aborted <= acc ? 1'b0 : ab_hit ? 1'b1 : aborted;
         if (acc) begin
            pick <= cmd.pick_angle;
            drop <= cmd.drop_angle;
         end
      end
endmodule

// File: tb/tb_crane_ctrl_gen2.sv
// tb_crane_ctrl_gen2: directed self-checking bench for crane_ctrl_gen2 with default parameters.
module tb_crane_ctrl_gen2;
   logic       clk, reset, hooked, unhooked, busy, done, aborted;
   logic [1:0] angle;
   logic [2:0] height, action;
`ifdef CRANE_HOOK_TIMEOUT_EN
   logic       fault;
`endif
   int checks = 0, failures = 0, n;
   crane_ctrl_gen2_if #(.ANG_W(2)) cmd_if ();
   crane_ctrl_gen2 dut (
      .clk(clk), .reset(reset), .cmd(cmd_if), .hooked(hooked), .unhooked(unhooked),
      .angle(angle), .height(height), .action(action), .busy(busy), .done(done), .aborted(aborted)
`ifdef CRANE_HOOK_TIMEOUT_EN
      , .fault(fault)
`endif
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step(input int k = 1);
      repeat (k) @(negedge clk);
   endtask
   task automatic measure(input logic [2:0] act, output int cnt);
      cnt = 0;
      while (action === act && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
   endtask
   task automatic wait_act(input string tag, input logic [2:0] act);
      int k = 0;
      while (action !== act && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(action), 32'(act));
   endtask
   task automatic wait_done(input string tag);
      int k = 0;
      while (done !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(done), 1);
   endtask
   task automatic issue(input logic [1:0] p, input logic [1:0] d);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.pick_angle = p;
      cmd_if.drop_angle = d;
      step();
      cmd_if.cmd_valid = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b0; hooked = 1'b0; unhooked = 1'b0;
      cmd_if.cmd_valid = 1'b0; cmd_if.pick_angle = '0; cmd_if.drop_angle = '0; cmd_if.abort = 1'b0;
      step(2);
      chk("rst_angle", 32'(angle), 0);
      chk("rst_height", 32'(height), 6);
      chk("rst_action", 32'(action), 6);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_aborted", 32'(aborted), 0);
      chk("rst_ready", 32'(cmd_if.cmd_ready), 1);
      reset = 1'b1;
      step();
      // job 1: full sequence, pick=1 drop=2
      issue(2'd1, 2'd2);
      chk("j1_busy", 32'(busy), 1);
      chk("j1_ready", 32'(cmd_if.cmd_ready), 0);
      measure(3'd7, n); chk("j1_rot_pick_len", n, 4);
      chk("j1_pick_angle", 32'(angle), 1);
      measure(3'd0, n); chk("j1_lower_len", n, 6);
      chk("j1_hook_height", 32'(height), 0);
      step(20);
      chk("j1_hook_wait", 32'(action), 1);
      hooked = 1'b1; step(); hooked = 1'b0;
      chk("j1_raise_act", 32'(action), 2);
      measure(3'd2, n); chk("j1_raise_len", n, 4);
      chk("j1_carry_height", 32'(height), 4);
      measure(3'd7, n); chk("j1_rot_drop_len", n, 4);
      chk("j1_drop_angle", 32'(angle), 2);
      measure(3'd0, n); chk("j1_lower2_len", n, 4);
      chk("j1_unhook_act", 32'(action), 3);
      unhooked = 1'b1; step(); unhooked = 1'b0;
      chk("j1_r1_act", 32'(action), 4);
      measure(3'd4, n); chk("j1_r1_len", n, 6);
      chk("j1_home_height", 32'(height), 6);
      measure(3'd7, n); chk("j1_rot_home_len", n, 7);
      chk("j1_done", 32'(done), 1);
      chk("j1_end_angle", 32'(angle), 0);
      chk("j1_r2", 32'(action), 5);
      chk("j1_ready_end", 32'(cmd_if.cmd_ready), 1);
      step();
      chk("j1_done_pulse", 32'(done), 0);
      chk("j1_r2_hold", 32'(action), 5);
      // job 2: pick=3 takes the single -1 step; abort in ROT_PICK
      issue(2'd3, 2'd0);
      step(3);
      chk("j2_minus_step", 32'(angle), 3);
      cmd_if.abort = 1'b1; step(); cmd_if.abort = 1'b0;
      chk("j2_abort_act", 32'(action), 4);
      chk("j2_aborted", 32'(aborted), 1);
      wait_done("j2_done");
      chk("j2_home_angle", 32'(angle), 0);
      step();
      chk("j2_aborted_sticky", 32'(aborted), 1);
      // job 3: pick=2 tie goes +1; abort in LOWER_PICK at height 3
      issue(2'd2, 2'd1);
      chk("j3_aborted_clr", 32'(aborted), 0);
      step(3);
      chk("j3_tie_first", 32'(angle), 1);
      step(3);
      chk("j3_tie_second", 32'(angle), 2);
      chk("j3_still_rot", 32'(action), 7);
      step();
      chk("j3_lower", 32'(action), 0);
      step(3);
      chk("j3_h3", 32'(height), 3);
      cmd_if.abort = 1'b1; step(); cmd_if.abort = 1'b0;
      chk("j3_abort_act", 32'(action), 4);
      chk("j3_aborted", 32'(aborted), 1);
      chk("j3_abort_height", 32'(height), 3);
      measure(3'd4, n); chk("j3_r1_len", n, 3);
      chk("j3_r1_height", 32'(height), 6);
      wait_done("j3_done");
      chk("j3_home_angle", 32'(angle), 0);
      step();
      // job 4: pick=0 one-cycle rotate, hooked beats abort, abort ignored in RAISE, reset mid-job
      issue(2'd0, 2'd3);
      chk("j4_rot_act", 32'(action), 7);
      measure(3'd7, n); chk("j4_rot_len", n, 1);
      measure(3'd0, n); chk("j4_lower_len", n, 6);
      hooked = 1'b1; cmd_if.abort = 1'b1; step(); hooked = 1'b0; cmd_if.abort = 1'b0;
      chk("j4_hook_wins", 32'(action), 2);
      chk("j4_not_aborted", 32'(aborted), 0);
      step();
      cmd_if.abort = 1'b1; step(); cmd_if.abort = 1'b0;
      chk("j4_raise_abort_act", 32'(action), 2);
      chk("j4_raise_abort_flag", 32'(aborted), 0);
      chk("j4_raise_h2", 32'(height), 2);
      measure(3'd2, n); chk("j4_raise_rest", n, 2);
      measure(3'd7, n); chk("j4_rot_drop_len", n, 4);
      chk("j4_drop_angle", 32'(angle), 3);
      step(2);
      chk("j4_lower_h2", 32'(height), 2);
      reset = 1'b0;
      #1;
      chk("j4_rst_angle", 32'(angle), 0);
      chk("j4_rst_height", 32'(height), 6);
      chk("j4_rst_action", 32'(action), 6);
      chk("j4_rst_busy", 32'(busy), 0);
      step();
      reset = 1'b1;
      step();
      // job 5: cmd_valid held high, inputs changed while busy, back-to-back accept
      hooked = 1'b1; unhooked = 1'b1;
      cmd_if.cmd_valid = 1'b1; cmd_if.pick_angle = 2'd1; cmd_if.drop_angle = 2'd3;
      step();
      chk("j5_busy", 32'(busy), 1);
      cmd_if.pick_angle = 2'd0; cmd_if.drop_angle = 2'd0;
      wait_act("j5_unhook", 3'd3);
      chk("j5_latched_drop", 32'(angle), 3);
      wait_done("j5_done");
      chk("j5_home_angle", 32'(angle), 0);
      cmd_if.pick_angle = 2'd3; cmd_if.drop_angle = 2'd2;
      step();
      chk("j5_b2b_busy", 32'(busy), 1);
      chk("j5_b2b_act", 32'(action), 7);
      step(3);
      chk("j5_b2b_pick", 32'(angle), 3);
      cmd_if.cmd_valid = 1'b0;
      wait_done("j5_done2");
      chk("j5_end_angle", 32'(angle), 0);
      step();
      chk("j5_idle", 32'(busy), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
